// File: rtl/rr_exe_lane_buffer_pkg.sv
// Shared constants and types for the register-read to execute lane buffer.
// Lane ordering and pack widths match the issue stage's lane assignment.
package rr_exe_lane_buffer_pkg;

  localparam int unsigned RR_SPEC_TAG_W = 4;
  typedef logic [RR_SPEC_TAG_W-1:0] spec_tag_t;

  localparam int unsigned RR_NUM_LANES = 3;
  typedef enum logic [1:0] {
    LANE_ALU_BC_CSR,
    LANE_ALU_MULDIV,
    LANE_MEM
  } rr_lane_e;

  localparam int unsigned INT_ISSUE_PACK_W        = 128;
  localparam int unsigned INT_ISSUE_NO_CSR_PACK_W = 112;
  localparam int unsigned MEM_ISSUE_PACK_W        = 120;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One common lane width so every lane can carry the widest pack.
  localparam int unsigned RR_PAYLOAD_W =
      max3(INT_ISSUE_PACK_W, INT_ISSUE_NO_CSR_PACK_W, MEM_ISSUE_PACK_W);

endpackage

// File: rtl/rr_exe_lane_buf.sv
// One issue lane: 2-entry head/skid buffer with in-place branch kill/clear
// and flush. Outputs come straight from the head registers.
module rr_exe_lane_buf
  import rr_exe_lane_buffer_pkg::*;
#(
  parameter int unsigned PAYLOAD_W  = RR_PAYLOAD_W,
  parameter int unsigned SPEC_TAG_W = RR_SPEC_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [PAYLOAD_W-1:0]  in_pack_i,
  input  logic [SPEC_TAG_W-1:0] in_br_mask_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [PAYLOAD_W-1:0]  out_pack_o,
  output logic [SPEC_TAG_W-1:0] out_br_mask_o,
  input  logic                  out_ready_i,
  input  logic                  br_res_valid_i,
  input  logic [SPEC_TAG_W-1:0] br_res_tag_i,
  input  logic                  br_res_mispredict_i
);

  logic                  h_valid_q, h_valid_d, s_valid_q, s_valid_d;
  logic [PAYLOAD_W-1:0]  h_pack_q, h_pack_d, s_pack_q, s_pack_d;
  logic [SPEC_TAG_W-1:0] h_mask_q, h_mask_d, s_mask_q, s_mask_d;

  logic                  consume, accept;
  logic                  kill_h, kill_s, kill_n;
  logic                  h_live, s_live, n_live;
  logic [SPEC_TAG_W-1:0] h_mask_r, s_mask_r, n_mask_r;

  assign in_ready_o    = rst_n & ~s_valid_q;
  assign out_valid_o   = rst_n & h_valid_q;
  assign out_pack_o    = h_pack_q;
  assign out_br_mask_o = h_mask_q;

  assign consume = h_valid_q & out_ready_i;
  assign accept  = in_valid_i & in_ready_o;

  // Clearing the tag bit is harmless for entries that are killed or untouched.
  assign kill_h   = br_res_valid_i & br_res_mispredict_i & (|(h_mask_q & br_res_tag_i));
  assign kill_s   = br_res_valid_i & br_res_mispredict_i & (|(s_mask_q & br_res_tag_i));
  assign kill_n   = br_res_valid_i & br_res_mispredict_i & (|(in_br_mask_i & br_res_tag_i));
  assign h_mask_r = br_res_valid_i ? (h_mask_q & ~br_res_tag_i) : h_mask_q;
  assign s_mask_r = br_res_valid_i ? (s_mask_q & ~br_res_tag_i) : s_mask_q;
  assign n_mask_r = br_res_valid_i ? (in_br_mask_i & ~br_res_tag_i) : in_br_mask_i;

  assign h_live = h_valid_q & ~consume & ~kill_h;
  assign s_live = s_valid_q & ~kill_s;
  assign n_live = accept & ~kill_n;

  // Survivors in age order (H, S, incoming) compact into H first, then S.
  always_comb begin
    h_valid_d = 1'b0;
    s_valid_d = 1'b0;
    h_pack_d  = h_pack_q;
    h_mask_d  = h_mask_q;
    s_pack_d  = s_pack_q;
    s_mask_d  = s_mask_q;
    if (!flush_i) begin
      if (h_live) begin
        h_valid_d = 1'b1;
        h_mask_d  = h_mask_r;
        if (s_live) begin
          s_valid_d = 1'b1;
          s_mask_d  = s_mask_r;
        end else if (n_live) begin
          s_valid_d = 1'b1;
          s_pack_d  = in_pack_i;
          s_mask_d  = n_mask_r;
        end
      end else if (s_live) begin
        h_valid_d = 1'b1;
        h_pack_d  = s_pack_q;
        h_mask_d  = s_mask_r;
        if (n_live) begin
          s_valid_d = 1'b1;
          s_pack_d  = in_pack_i;
          s_mask_d  = n_mask_r;
        end
      end else if (n_live) begin
        h_valid_d = 1'b1;
        h_pack_d  = in_pack_i;
        h_mask_d  = n_mask_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      h_pack_q  <= '0;
      h_mask_q  <= '0;
      s_pack_q  <= '0;
      s_mask_q  <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      s_valid_q <= s_valid_d;
      h_pack_q  <= h_pack_d;
      h_mask_q  <= h_mask_d;
      s_pack_q  <= s_pack_d;
      s_mask_q  <= s_mask_d;
    end
  end

endmodule

// File: rtl/rr_exe_lane_buffer.sv
// Register-read to execute buffer: independent per-lane skid buffers sharing
// flush and branch-resolution broadcast.
module rr_exe_lane_buffer
  import rr_exe_lane_buffer_pkg::*;
#(
  parameter int unsigned NUM_LANES  = RR_NUM_LANES,
  parameter int unsigned PAYLOAD_W  = RR_PAYLOAD_W,
  parameter int unsigned SPEC_TAG_W = RR_SPEC_TAG_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic [NUM_LANES-1:0]            in_valid_i,
  input  logic [NUM_LANES*PAYLOAD_W-1:0]  in_pack_i,
  input  logic [NUM_LANES*SPEC_TAG_W-1:0] in_br_mask_i,
  output logic [NUM_LANES-1:0]            in_ready_o,
  output logic [NUM_LANES-1:0]            out_valid_o,
  output logic [NUM_LANES*PAYLOAD_W-1:0]  out_pack_o,
  output logic [NUM_LANES*SPEC_TAG_W-1:0] out_br_mask_o,
  input  logic [NUM_LANES-1:0]            out_ready_i,
  input  logic                            br_res_valid_i,
  input  logic [SPEC_TAG_W-1:0]           br_res_tag_i,
  input  logic                            br_res_mispredict_i
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_exe_lane_buf #(
      .PAYLOAD_W  (PAYLOAD_W),
      .SPEC_TAG_W (SPEC_TAG_W)
    ) u_lane (
      .clk                 (clk),
      .rst_n               (rst_n),
      .flush_i             (flush_i),
      .in_valid_i          (in_valid_i[g]),
      .in_pack_i           (in_pack_i[g*PAYLOAD_W +: PAYLOAD_W]),
      .in_br_mask_i        (in_br_mask_i[g*SPEC_TAG_W +: SPEC_TAG_W]),
      .in_ready_o          (in_ready_o[g]),
      .out_valid_o         (out_valid_o[g]),
      .out_pack_o          (out_pack_o[g*PAYLOAD_W +: PAYLOAD_W]),
      .out_br_mask_o       (out_br_mask_o[g*SPEC_TAG_W +: SPEC_TAG_W]),
      .out_ready_i         (out_ready_i[g]),
      .br_res_valid_i      (br_res_valid_i),
      .br_res_tag_i        (br_res_tag_i),
      .br_res_mispredict_i (br_res_mispredict_i)
    );
  end

endmodule

// File: tb/tb_rr_exe_lane_buffer.sv
// Bench for rr_exe_lane_buffer: per-lane FIFO model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_rr_exe_lane_buffer;
  localparam int NL = 3;
  localparam int PW = 128;
  localparam int TW = 4;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic [NL-1:0]    in_valid_i;
  logic [NL*PW-1:0] in_pack_i;
  logic [NL*TW-1:0] in_br_mask_i;
  logic [NL-1:0]    in_ready_o;
  logic [NL-1:0]    out_valid_o;
  logic [NL*PW-1:0] out_pack_o;
  logic [NL*TW-1:0] out_br_mask_o;
  logic [NL-1:0]    out_ready_i;
  logic             br_res_valid_i;
  logic [TW-1:0]    br_res_tag_i;
  logic             br_res_mispredict_i;

  rr_exe_lane_buffer #(
    .NUM_LANES  (NL),
    .PAYLOAD_W  (PW),
    .SPEC_TAG_W (TW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush_i),
    .in_valid_i          (in_valid_i),
    .in_pack_i           (in_pack_i),
    .in_br_mask_i        (in_br_mask_i),
    .in_ready_o          (in_ready_o),
    .out_valid_o         (out_valid_o),
    .out_pack_o          (out_pack_o),
    .out_br_mask_o       (out_br_mask_o),
    .out_ready_i         (out_ready_i),
    .br_res_valid_i      (br_res_valid_i),
    .br_res_tag_i        (br_res_tag_i),
    .br_res_mispredict_i (br_res_mispredict_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: each lane is an in-order queue of at most 2 {pack, mask} entries.
  int            m_cnt [NL];
  logic [PW-1:0] m_pack[NL][2];
  logic [TW-1:0] m_mask[NL][2];

  task automatic chk(input string name, input int lane, input logic [PW-1:0] got,
                     input logic [PW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s lane=%0d got=%h want=%h", name, lane, got, want);
    end
  endtask

  function automatic logic [PW-1:0] head_pack(input int l);
    return out_pack_o[l*PW +: PW];
  endfunction

  function automatic logic [TW-1:0] head_mask(input int l);
    return out_br_mask_o[l*TW +: TW];
  endfunction

  function automatic logic [PW-1:0] rnd_pack();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_step();
    for (int l = 0; l < NL; l++) begin
      logic [PW-1:0] cp[3];
      logic [TW-1:0] cm[3];
      int            cn;
      int            n;
      logic          acc;
      if (!rst_n || flush_i) begin
        m_cnt[l] = 0;
        continue;
      end
      acc = in_valid_i[l] && (m_cnt[l] < 2);
      cn  = 0;
      for (int e = 0; e < m_cnt[l]; e++) begin
        if (e == 0 && out_ready_i[l]) continue;
        cp[cn] = m_pack[l][e];
        cm[cn] = m_mask[l][e];
        cn++;
      end
      if (acc) begin
        cp[cn] = in_pack_i[l*PW +: PW];
        cm[cn] = in_br_mask_i[l*TW +: TW];
        cn++;
      end
      n = 0;
      for (int e = 0; e < cn; e++) begin
        logic [TW-1:0] mk;
        mk = cm[e];
        if (br_res_valid_i && ((mk & br_res_tag_i) != '0)) begin
          if (br_res_mispredict_i) continue;
          mk = mk & ~br_res_tag_i;
        end
        if (n < 2) begin
          m_pack[l][n] = cp[e];
          m_mask[l][n] = mk;
        end
        n++;
      end
      m_cnt[l] = (n > 2) ? 2 : n;
    end
  endtask

  task automatic compare_all();
    for (int l = 0; l < NL; l++) begin
      chk("in_ready", l, PW'(in_ready_o[l]), PW'(rst_n && (m_cnt[l] < 2)));
      chk("out_valid", l, PW'(out_valid_o[l]), PW'(rst_n && (m_cnt[l] > 0)));
      if (rst_n && m_cnt[l] > 0) begin
        chk("out_pack", l, head_pack(l), m_pack[l][0]);
        chk("out_mask", l, PW'(head_mask(l)), PW'(m_mask[l][0]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    flush_i             = 1'b0;
    in_valid_i          = '0;
    in_pack_i           = '0;
    in_br_mask_i        = '0;
    out_ready_i         = '0;
    br_res_valid_i      = 1'b0;
    br_res_tag_i        = '0;
    br_res_mispredict_i = 1'b0;
  endtask

  task automatic drive_lane(input int l, input logic [PW-1:0] p, input logic [TW-1:0] m);
    in_valid_i[l]          = 1'b1;
    in_pack_i[l*PW +: PW]  = p;
    in_br_mask_i[l*TW +: TW] = m;
  endtask

  initial begin
    for (int l = 0; l < NL; l++) m_cnt[l] = 0;
    rst_n = 1'b0;
    set_idle();

    // Reset state
    cycle();
    cycle();
    chk("rst_out_valid", -1, PW'(out_valid_o), PW'(0));
    chk("rst_in_ready", -1, PW'(in_ready_o), PW'(0));
    for (int l = 0; l < NL; l++) begin
      chk("rst_pack", l, head_pack(l), '0);
      chk("rst_mask", l, PW'(head_mask(l)), PW'(0));
    end
    rst_n = 1'b1;
    cycle();
    chk("post_rst_in_ready", -1, PW'(in_ready_o), PW'(3'b111));

    // Streaming on lane 0
    out_ready_i = '1;
    for (int k = 0; k < 8; k++) begin
      drive_lane(0, PW'(8'h11 + k), '0);
      cycle();
      chk("stream_pack", 0, head_pack(0), PW'(8'h11 + k));
      chk("stream_ready", 0, PW'(in_ready_o[0]), PW'(1));
    end
    set_idle();
    cycle();

    // Stall on lane 1: second pack lands in skid, ready drops
    for (int i = 0; i < 4; i++) begin
      set_idle();
      out_ready_i[1] = (i == 0);
      drive_lane(1, PW'(8'h21 + i), '0);
      cycle();
      if (i == 1) begin
        chk("stall_ready", 1, PW'(in_ready_o[1]), PW'(0));
        chk("stall_head", 1, head_pack(1), PW'(8'h21));
      end
    end
    set_idle();
    out_ready_i = '1;
    cycle();
    chk("drain_head", 1, head_pack(1), PW'(8'h22));
    cycle();
    chk("drain_empty", 1, PW'(out_valid_o[1]), PW'(0));

    // Mispredict on lane 2 kills head, skid moves up
    set_idle();
    drive_lane(2, PW'(8'h31), 4'b0010);
    cycle();
    drive_lane(2, PW'(8'h32), 4'b0100);
    cycle();
    set_idle();
    br_res_valid_i = 1'b1; br_res_tag_i = 4'b0010; br_res_mispredict_i = 1'b1;
    cycle();
    chk("misp_pack", 2, head_pack(2), PW'(8'h32));
    chk("misp_mask", 2, PW'(head_mask(2)), PW'(4'b0100));
    set_idle();
    out_ready_i = '1;
    cycle();
    cycle();

    // Correct prediction clears bit in stored and incoming entries
    set_idle();
    drive_lane(0, PW'(8'h41), 4'b0110);
    cycle();
    set_idle();
    drive_lane(0, PW'(8'h42), 4'b0100);
    br_res_valid_i = 1'b1; br_res_tag_i = 4'b0100; br_res_mispredict_i = 1'b0;
    cycle();
    chk("corr_head_pack", 0, head_pack(0), PW'(8'h41));
    chk("corr_head_mask", 0, PW'(head_mask(0)), PW'(4'b0010));
    set_idle();
    out_ready_i = '1;
    cycle();
    chk("corr_next_pack", 0, head_pack(0), PW'(8'h42));
    chk("corr_next_mask", 0, PW'(head_mask(0)), PW'(4'b0000));
    cycle();

    // Flush with all lanes full and a concurrent accept
    set_idle();
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < NL; l++) drive_lane(l, PW'(8'h60 + 8'(l * 4 + c)), '0);
      cycle();
    end
    flush_i = 1'b1;
    for (int l = 0; l < NL; l++) drive_lane(l, PW'(16'hDEAD), '0);
    cycle();
    chk("flush_valid", -1, PW'(out_valid_o), PW'(0));
    chk("flush_ready", -1, PW'(in_ready_o), PW'(3'b111));
    set_idle();
    out_ready_i = '1;
    cycle();
    chk("flush_no_ghost", -1, PW'(out_valid_o), PW'(0));

    // Reset mid-operation
    set_idle();
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < NL; l++) drive_lane(l, PW'(8'h70 + 8'(l * 4 + c)), '0);
      cycle();
    end
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", -1, PW'(out_valid_o), PW'(0));
    chk("rst_mid_ready", -1, PW'(in_ready_o), PW'(0));
    cycle();
    chk("rst_hold_valid", -1, PW'(out_valid_o), PW'(0));
    rst_n = 1'b1;
    cycle();
    chk("rst_rel_ready", -1, PW'(in_ready_o), PW'(3'b111));
    chk("rst_rel_valid", -1, PW'(out_valid_o), PW'(0));
    out_ready_i = '1;
    drive_lane(0, PW'(8'h55), '0);
    cycle();
    chk("rst_reaccept", 0, head_pack(0), PW'(8'h55));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n               = ($urandom_range(0, 199) != 0);
      flush_i             = ($urandom_range(0, 39) == 0);
      in_valid_i          = NL'($urandom_range(0, 7));
      out_ready_i         = NL'($urandom_range(0, 7));
      br_res_valid_i      = ($urandom_range(0, 3) == 0);
      br_res_tag_i        = TW'(1) << $urandom_range(0, TW - 1);
      br_res_mispredict_i = $urandom_range(0, 1) != 0;
      for (int l = 0; l < NL; l++) begin
        in_pack_i[l*PW +: PW]    = rnd_pack();
        in_br_mask_i[l*TW +: TW] = TW'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_exe_lane_buffer.md
# rr_exe_lane_buffer

Parametrised register-read to execute pipeline buffer that replaces the bare valid/pack hand-off with registered, back-pressurable lanes. Each of NUM_LANES issue lanes (ALU/BC/CSR, ALU/MulDiv, MEM by default) owns a 2-entry skid buffer carrying an opaque issue pack plus its speculative branch mask. Entries are killed or un-speculated in place on branch resolution, and the whole buffer clears on pipeline flush. It sits between the register read stage and the execute units, and decouples execute stalls from register read timing.

## Interface
- NUM_LANES, 3, number of independent issue lanes
- PAYLOAD_W, 128, width of each lane's issue pack (packed struct, opaque to this block)
- SPEC_TAG_W, 4, width of the branch mask (one bit per in-flight branch)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush_i  in  1  pipeline flush; drop all entries
- in_valid_i  in  NUM_LANES  per-lane issue pack valid from register read
- in_pack_i  in  NUM_LANES*PAYLOAD_W  per-lane issue pack
- in_br_mask_i  in  NUM_LANES*SPEC_TAG_W  per-lane branch mask of incoming pack
- in_ready_o  out  NUM_LANES  lane can accept this cycle
- out_valid_o  out  NUM_LANES  head entry valid to execute unit
- out_pack_o  out  NUM_LANES*PAYLOAD_W  head entry pack
- out_br_mask_o  out  NUM_LANES*SPEC_TAG_W  head entry mask, already updated by past resolutions
- out_ready_i  in  NUM_LANES  execute unit consumes head this cycle
- br_res_valid_i  in  1  branch resolution event
- br_res_tag_i  in  SPEC_TAG_W  one-hot tag of resolved branch
- br_res_mispredict_i  in  1  1 = mispredicted (kill), 0 = correct (clear bit)

## Operation
- Per lane: head entry H and skid entry S, each {valid, pack, mask}. Lanes are fully independent; order is preserved within a lane.
- in_ready_o[l] = rst_n & ~S.valid. This is a function of registered state only; there is no combinational path from out_ready_i.
- Accept when in_valid_i & in_ready_o. Consume when out_valid_o & out_ready_i.
- Next-state for each lane:
  - Entries update in this order: consume removes H; S promotes to H if H is empty or consumed; the accepted pack fills H if H is free after promotion, otherwise S.
- Branch resolution applies in the same cycle to H, S and the pack being accepted:
  - If mask & tag != 0 and mispredict: the entry is invalidated.
  - If mask & tag != 0 and correct: the tag bit is cleared in the stored mask.
  - Survivors compact so that H is filled whenever any entry survives.
- Kill and consume in the same cycle on H: the consume is counted.
  - The execute unit owns squashing by resolution; this block only guarantees the entry is not presented again.
- flush_i: all valid bits go to 0 next cycle, and any accept that cycle is discarded. flush_i has priority over resolution, accept and promotion.
- br_res_tag_i with more than one bit set is illegal. Behaviour then is an undefined kill set, but lanes must not corrupt each other.
- Pack contents are not interpreted. The mask is only ANDed and cleared.

## Timing
- Reset (rst_n low at a clock edge): H.valid = S.valid = 0 for all lanes.
  - out_valid_o = 0 and in_ready_o = 0 while rst_n is low; in_ready_o = 1 from the first cycle after release.
  - out_pack_o and out_br_mask_o reset to 0.
- Latency: accept in cycle N means out_valid_o in cycle N+1 (empty lane).
- Throughput: 1 pack/cycle/lane sustained while out_ready_i = 1.
- Back-pressure: out_ready_i low lets one extra pack be absorbed into S. in_ready_o drops in the following cycle.
- out_valid_o, out_pack_o and out_br_mask_o are registered. Resolution effects on stored entries are visible in the cycle after br_res_valid_i.
- Reset or flush mid-stream: no entry accepted before the event is ever presented afterwards.

## Structure
- Falco_pkg additions:
  - SPEC_TAG_W constant and spec_tag_t typedef.
  - RR_NUM_LANES constant and lane index enum (LANE_ALU_BC_CSR, LANE_ALU_MULDIV, LANE_MEM).
  - Pack width constants derived from int_issue_pack_t, int_issue_no_csr_pack_t and mem_issue_pack_t.
- Sub-module rr_exe_lane_buf: one lane (H/S, handshake, resolution, flush), instantiated NUM_LANES times by generate.
- The top level only fans out flush/resolution and slices the buses.

## Test plan
- Streaming: out_ready_i = 1, lane 0 receives packs 0x11..0x18 on 8 consecutive cycles -> out_pack_o shows 0x11..0x18 one cycle delayed; in_ready_o stays 1.
- Stall: out_ready_i = 0 from cycle 2, in_valid_i held high -> 2 packs are stored and in_ready_o = 0 from cycle 3. Releasing the stall drains both in order with no loss or duplicate.
- Mispredict: H mask = 4'b0010, S mask = 4'b0100, br_res_tag_i = 4'b0010 with mispredict = 1 -> next cycle S's pack is at the head, mask 4'b0100.
- Correct prediction: H mask = 4'b0110, tag 4'b0100 with mispredict = 0, and the accepted pack that cycle also carries mask 4'b0100 -> masks become 4'b0010 and 4'b0000.
- Flush: all 3 lanes full, flush_i = 1 together with in_valid_i = 1 -> next cycle all out_valid_o = 0 and in_ready_o = 1; the discarded pack never appears.
- Reset mid-operation: rst_n low for 1 cycle with lanes holding data -> out_valid_o = 0 and in_ready_o = 0 during reset. After release, the lanes are empty and accept normally.
